alu_control_unit: RTL and testbench

- Multi-cycle instruction sequencer for the 8-bit datapath.
- Fetches 16-bit instructions over a valid-handshake instruction port, decodes them and drives the ALU 3-bit op select and the register-file addresses and write enable.
- Keeps the PC and a registered zero flag taken from the ALU's Z output, and uses that flag for conditional branches.
- Sits between instruction memory and the datapath (register file + ALU).

---
 rtl/cu_pkg.sv | 33 +++
 rtl/alu_control_unit_if.sv | 12 +
 rtl/cu_decoder.sv | 43 ++++
 rtl/alu_control_unit.sv | 129 ++++++++++++
 tb/tb_alu_control_unit.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the ALU control unit: opcodes, ALU select codes and FSM states.
package cu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SHL  = 4'h5;
    localparam logic [3:0] OP_SHR  = 4'h6;
    localparam logic [3:0] OP_LDI  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_JNZ  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    // 3'b001 is reserved on the ALU and never issued.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_SHL = 3'b110;
    localparam logic [2:0] ALU_SHR = 3'b111;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

endpackage

// File: rtl/alu_control_unit_if.sv
// Instruction-fetch port: request/address out of the sequencer, word/valid back from memory.
interface alu_control_unit_if #(
    parameter int PC_W = 8
);
    logic            req;
    logic [PC_W-1:0] addr;
    logic [15:0]     rdata;
    logic            valid;

    modport master (output req, output addr, input rdata, input valid);
    modport slave  (input req, input addr, output rdata, output valid);
endinterface

// File: rtl/cu_decoder.sv
// Combinational opcode decoder: ir[15:12] to ALU select and instruction-class flags.
module cu_decoder
    import cu_pkg::*;
(
    input  logic [3:0] op,
    output logic [2:0] alu_sel,
    output logic       is_alu,
    output logic       is_ldi,
    output logic       is_jmp,
    output logic       is_jz,
    output logic       is_jnz,
    output logic       is_halt,
    output logic       is_illegal
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        alu_sel    = ALU_ADD;
        is_alu     = 1'b0;
        is_ldi     = 1'b0;
        is_jmp     = 1'b0;
        is_jz      = 1'b0;
        is_jnz     = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (op)
            OP_ADD:  begin alu_sel = ALU_ADD; is_alu = 1'b1; end
            OP_SUB:  begin alu_sel = ALU_SUB; is_alu = 1'b1; end
            OP_AND:  begin alu_sel = ALU_AND; is_alu = 1'b1; end
            OP_OR:   begin alu_sel = ALU_OR;  is_alu = 1'b1; end
            OP_XOR:  begin alu_sel = ALU_XOR; is_alu = 1'b1; end
            OP_SHL:  begin alu_sel = ALU_SHL; is_alu = 1'b1; end
            OP_SHR:  begin alu_sel = ALU_SHR; is_alu = 1'b1; end
            OP_LDI:  is_ldi  = 1'b1;
            OP_JMP:  is_jmp  = 1'b1;
            OP_JZ:   is_jz   = 1'b1;
            OP_JNZ:  is_jnz  = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer driving ALU select and register-file controls.
// Define CU_ILLEGAL_TRAP_EN to trap opcodes B-E into HALT with a sticky illegal flag.
module alu_control_unit
    import cu_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_control_unit_if.master  imem,
    output logic [2:0]          alu_sel,
    input  logic                alu_z,
    output logic [2:0]          rf_raddr1,
    output logic [2:0]          rf_raddr2,
    output logic [2:0]          rf_waddr,
    output logic                rf_we,
    output logic                wb_imm,
    output logic [7:0]          imm,
    output logic                z_flag,
    output logic                halted,
    output logic                illegal
);

`ifdef CU_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc;
    logic [15:0]     ir;
    logic            z_q;

    logic [2:0] dec_alu_sel;
    logic       is_alu, is_ldi, is_jmp, is_jz, is_jnz, is_halt, is_illegal;
    logic       taken, trap;
    logic [PC_W-1:0] target;

    cu_decoder u_dec (
        .op         (ir[15:12]),
        .alu_sel    (dec_alu_sel),
        .is_alu     (is_alu),
        .is_ldi     (is_ldi),
        .is_jmp     (is_jmp),
        .is_jz      (is_jz),
        .is_jnz     (is_jnz),
        .is_halt    (is_halt),
        .is_illegal (is_illegal)
    );

    assign target = PC_W'(ir[7:0]);
    assign taken  = is_jmp | (is_jz & z_q) | (is_jnz & ~z_q);
    assign trap   = is_illegal & TRAP_EN;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (imem.valid) state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC:   state_nxt = (is_halt || trap) ? S_HALT : S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        imem.req = 1'b0;
        alu_sel  = ALU_ADD;
        rf_we    = 1'b0;
        wb_imm   = 1'b0;
        halted   = 1'b0;
        case (state)
            S_FETCH:  imem.req = 1'b1;
            S_DECODE: alu_sel = dec_alu_sel;
            S_EXEC: begin
                alu_sel = dec_alu_sel;
                rf_we   = is_alu | is_ldi;
                wb_imm  = is_ldi;
            end
            S_HALT:   halted = 1'b1;
            default:  ;
        endcase
    end

    // Instruction register, PC and zero flag; HALT and trapped opcodes leave the PC in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc  <= RESET_PC;
            ir  <= '0;
            z_q <= 1'b0;
        end else begin
            case (state)
                S_FETCH: if (imem.valid) ir <= imem.rdata;
                S_EXEC: begin
                    if (is_alu) z_q <= alu_z;
                    if (!(is_halt || trap)) pc <= taken ? target : pc + PC_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef CU_ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         illegal_q <= 1'b0;
        else if (state == S_EXEC && trap)   illegal_q <= 1'b1;
    end
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign imem.addr = pc;
    assign rf_raddr1 = ir[8:6];
    assign rf_raddr2 = ir[5:3];
    assign rf_waddr  = ir[11:9];
    assign imm       = ir[7:0];
    assign z_flag    = z_q;

endmodule

// File: tb/tb_alu_control_unit.sv
// Directed self-checking bench for alu_control_unit; follows CU_ILLEGAL_TRAP_EN if defined.
module tb_alu_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alu_z;
    logic [2:0] alu_sel, rf_raddr1, rf_raddr2, rf_waddr;
    logic       rf_we, wb_imm, z_flag, halted, illegal;
    logic [7:0] imm;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Values captured during the last instruction's DECODE and EXEC cycles.
    logic [2:0] d_sel, d_r1, d_r2, e_sel, e_wa;
    logic       d_req, d_we, e_we, e_wb;
    logic [7:0] e_imm;
    int         wait_bad, lat;

    always #5 clk = ~clk;

    alu_control_unit_if #(.PC_W(8)) imem_if ();

    alu_control_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem      (imem_if),
        .alu_sel   (alu_sel),
        .alu_z     (alu_z),
        .rf_raddr1 (rf_raddr1),
        .rf_raddr2 (rf_raddr2),
        .rf_waddr  (rf_waddr),
        .rf_we     (rf_we),
        .wb_imm    (wb_imm),
        .imm       (imm),
        .z_flag    (z_flag),
        .halted    (halted),
        .illegal   (illegal)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        rst_n         = 1'b0;
        imem_if.valid = 1'b0;
        alu_z         = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    // Issue one instruction from FETCH with a number of memory wait cycles.
    task automatic run_instr(input logic [15:0] instr, input int waits, input logic zin);
        int         c0;
        logic [7:0] a0;
        c0       = cyc;
        a0       = imem_if.addr;
        wait_bad = 0;
        imem_if.valid = 1'b0;
        imem_if.rdata = 16'hDEAD;
        for (int i = 0; i < waits; i++) begin
            step();
            if (imem_if.req !== 1'b1 || rf_we !== 1'b0 || imem_if.addr !== a0) wait_bad++;
        end
        imem_if.rdata = instr;
        imem_if.valid = 1'b1;
        step();
        d_sel = alu_sel; d_r1 = rf_raddr1; d_r2 = rf_raddr2; d_req = imem_if.req; d_we = rf_we;
        imem_if.valid = 1'b0;
        imem_if.rdata = 16'hDEAD;
        alu_z = zin;
        step();
        e_sel = alu_sel; e_we = rf_we; e_wb = wb_imm; e_wa = rf_waddr; e_imm = imm;
        step();
        lat = cyc - c0;
    endtask

    initial begin
        rst_n         = 1'b0;
        alu_z         = 1'b0;
        imem_if.valid = 1'b0;
        imem_if.rdata = 16'h0000;
        apply_reset();

        check("rst_req",     16'(imem_if.req), 16'h1);
        check("rst_addr",    16'(imem_if.addr), 16'h00);
        check("rst_z",       16'(z_flag), 16'h0);
        check("rst_we",      16'(rf_we), 16'h0);
        check("rst_halted",  16'(halted), 16'h0);
        check("rst_illegal", 16'(illegal), 16'h0);
        check("rst_alusel",  16'(alu_sel), 16'h0);

        // LDI r1, 5 at pc 0
        run_instr(16'h7205, 0, 1'b0);
        check("ldi_dec_sel", 16'(d_sel), 16'h0);
        check("ldi_dec_req", 16'(d_req), 16'h0);
        check("ldi_dec_we",  16'(d_we), 16'h0);
        check("ldi_ex_we",   16'(e_we), 16'h1);
        check("ldi_ex_wb",   16'(e_wb), 16'h1);
        check("ldi_ex_wa",   16'(e_wa), 16'h1);
        check("ldi_ex_imm",  16'(e_imm), 16'h05);
        check("ldi_lat",     16'(lat), 16'd3);
        check("ldi_addr",    16'(imem_if.addr), 16'h01);
        check("ldi_z",       16'(z_flag), 16'h0);

        // SUB r3, r1, r1 with alu_z = 1
        run_instr(16'h1648, 0, 1'b1);
        check("sub_dec_sel", 16'(d_sel), 16'h2);
        check("sub_dec_r1",  16'(d_r1), 16'h1);
        check("sub_dec_r2",  16'(d_r2), 16'h1);
        check("sub_ex_sel",  16'(e_sel), 16'h2);
        check("sub_ex_we",   16'(e_we), 16'h1);
        check("sub_ex_wb",   16'(e_wb), 16'h0);
        check("sub_ex_wa",   16'(e_wa), 16'h3);
        check("sub_z",       16'(z_flag), 16'h1);
        check("sub_addr",    16'(imem_if.addr), 16'h02);

        // JZ 0x20 taken; alu_z low must not touch z_flag
        run_instr(16'h9020, 0, 1'b0);
        check("jz_ex_we",    16'(e_we), 16'h0);
        check("jz_ex_sel",   16'(e_sel), 16'h0);
        check("jz_addr",     16'(imem_if.addr), 16'h20);
        check("jz_z_keep",   16'(z_flag), 16'h1);

        // SUB with alu_z = 0, then JZ not taken
        run_instr(16'h1648, 0, 1'b0);
        check("sub0_z",      16'(z_flag), 16'h0);
        check("sub0_addr",   16'(imem_if.addr), 16'h21);
        run_instr(16'h9040, 0, 1'b1);
        check("jznt_addr",   16'(imem_if.addr), 16'h22);
        check("jznt_z",      16'(z_flag), 16'h0);

        // JNZ 0x30 taken while z_flag = 0
        run_instr(16'hA030, 0, 1'b0);
        check("jnz_addr",    16'(imem_if.addr), 16'h30);

        // ADD with four memory wait cycles
        run_instr(16'h0000, 4, 1'b1);
        check("wait_stable", 16'(wait_bad), 16'h0);
        check("wait_lat",    16'(lat), 16'd7);
        check("wait_ex_we",  16'(e_we), 16'h1);
        check("wait_addr",   16'(imem_if.addr), 16'h31);
        check("wait_z",      16'(z_flag), 16'h1);

        // JMP 0xFF then ADD at 0xFF wraps the PC
        run_instr(16'h80FF, 0, 1'b0);
        check("jmp_addr",    16'(imem_if.addr), 16'hFF);
        run_instr(16'h0000, 0, 1'b0);
        check("wrap_addr",   16'(imem_if.addr), 16'h00);
        check("wrap_z",      16'(z_flag), 16'h0);

        // XOR r5, r2, r3
        run_instr(16'h4A98, 0, 1'b0);
        check("xor_dec_sel", 16'(d_sel), 16'h5);
        check("xor_dec_r1",  16'(d_r1), 16'h2);
        check("xor_dec_r2",  16'(d_r2), 16'h3);
        check("xor_ex_wa",   16'(e_wa), 16'h5);
        check("xor_addr",    16'(imem_if.addr), 16'h01);

        // Opcode C at pc 1
        run_instr(16'hC000, 0, 1'b0);
        check("opc_ex_we",   16'(e_we), 16'h0);
`ifdef CU_ILLEGAL_TRAP_EN
        check("trap_halted", 16'(halted), 16'h1);
        check("trap_ill",    16'(illegal), 16'h1);
        check("trap_req",    16'(imem_if.req), 16'h0);
        check("trap_pc",     16'(imem_if.addr), 16'h01);
        apply_reset();
        check("trap_rst_ill", 16'(illegal), 16'h0);
`else
        check("nop_addr",    16'(imem_if.addr), 16'h02);
        check("nop_ill",     16'(illegal), 16'h0);
        check("nop_halted",  16'(halted), 16'h0);
`endif

        // HALT, with memory presenting valid words afterwards
        begin
            logic [7:0] hpc;
            hpc = imem_if.addr;
            run_instr(16'hF000, 0, 1'b0);
            check("halt_ex_we", 16'(e_we), 16'h0);
            imem_if.rdata = 16'h7205;
            imem_if.valid = 1'b1;
            for (int i = 0; i < 5; i++) begin
                check("halt_halted", 16'(halted), 16'h1);
                check("halt_req",    16'(imem_if.req), 16'h0);
                check("halt_we",     16'(rf_we), 16'h0);
                check("halt_pc",     16'(imem_if.addr), 16'(hpc));
                step();
            end
            imem_if.valid = 1'b0;
        end

        // Asynchronous reset in the middle of a DECODE cycle
        apply_reset();
        check("halt_rst_halted", 16'(halted), 16'h0);
        run_instr(16'h1648, 0, 1'b1);
        check("pre_z", 16'(z_flag), 16'h1);
        imem_if.rdata = 16'h1648;
        imem_if.valid = 1'b1;
        step();
        imem_if.valid = 1'b0;
        check("pre_dec_sel", 16'(alu_sel), 16'h2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req",    16'(imem_if.req), 16'h1);
        check("arst_addr",   16'(imem_if.addr), 16'h00);
        check("arst_z",      16'(z_flag), 16'h0);
        check("arst_sel",    16'(alu_sel), 16'h0);
        check("arst_we",     16'(rf_we), 16'h0);
        check("arst_halted", 16'(halted), 16'h0);
        check("arst_ill",    16'(illegal), 16'h0);
        check("arst_r1",     16'(rf_raddr1), 16'h0);
        step();
        rst_n = 1'b1;

        // Core resumes normally after reset
        run_instr(16'h7305, 0, 1'b0);
        check("post_ex_we",  16'(e_we), 16'h1);
        check("post_ex_wa",  16'(e_wa), 16'h1);
        check("post_addr",   16'(imem_if.addr), 16'h01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
